// File: rtl/mult_arbiter_if.sv
// Signal bundle between mult_arbiter, its two requesters and the shared mult_32 core.
// slave is the arbiter's view; master is the requester/core side.
interface mult_arbiter_if;
    logic        req0;
    logic        req1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        ack0;
    logic        ack1;
    logic [31:0] res;
    logic        err;
    logic        busy;
    logic        gnt_id;
    logic        m_init;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_done;
    logic [31:0] m_pp;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, m_done, m_pp,
        output ack0, ack1, res, err, busy, gnt_id, m_init, m_a, m_b
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, m_done, m_pp,
        input  ack0, ack1, res, err, busy, gnt_id, m_init, m_a, m_b
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one mult_32 core between two requesters.
// Define MULT_ARB_TIMEOUT_EN to build the RUN-state watchdog (limit TIMEOUT_CYCLES).
module mult_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset,
    mult_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t      state, state_next;
    logic        last_q, last_next;
    logic        gnt_q, gnt_next;
    logic        winner;
    logic [15:0] m_a_q, m_a_next;
    logic [15:0] m_b_q, m_b_next;
    logic [31:0] res_q, res_next;
    logic        ack0_q, ack0_next;
    logic        ack1_q, ack1_next;
    logic        err_q, err_next;
    logic        busy_q, busy_next;
    logic        m_init_q, m_init_next;
    logic        timed_out;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] run_cnt;

    // Counts RUN cycles; sits at zero everywhere else so each grant starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (state != RUN) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end

    assign timed_out = (run_cnt == CNT_LAST);
`else
    // Watchdog not built: this can never fire, so err stays low.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    // Only one request wins outright; a tie goes to whoever was not served last.
    assign winner = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            m_a_q    <= '0;
            m_b_q    <= '0;
            res_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            m_init_q <= 1'b0;
        end else begin
            state    <= state_next;
            last_q   <= last_next;
            gnt_q    <= gnt_next;
            m_a_q    <= m_a_next;
            m_b_q    <= m_b_next;
            res_q    <= res_next;
            ack0_q   <= ack0_next;
            ack1_q   <= ack1_next;
            err_q    <= err_next;
            busy_q   <= busy_next;
            m_init_q <= m_init_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last_q;
        gnt_next   = gnt_q;
        m_a_next   = m_a_q;
        m_b_next   = m_b_q;
        res_next   = res_q;
        ack0_next  = 1'b0;
        ack1_next  = 1'b0;
        err_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_next   = winner;
                    m_a_next   = winner ? bus.a1 : bus.a0;
                    m_b_next   = winner ? bus.b1 : bus.b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.m_done) begin
                    res_next   = bus.m_pp;
                    ack0_next  = ~gnt_q;
                    ack1_next  = gnt_q;
                    last_next  = gnt_q;
                    state_next = CLEAR;
                end else if (timed_out) begin
                    res_next   = 32'hFFFF_FFFF;
                    err_next   = 1'b1;
                    ack0_next  = ~gnt_q;
                    ack1_next  = gnt_q;
                    last_next  = gnt_q;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                // The core must see init low with done released before the next grant.
                if (!bus.m_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        m_init_next = (state_next == RUN);
        busy_next   = (state_next != IDLE);
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.res    = res_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.gnt_id = gnt_q;
    assign bus.m_init = m_init_q;
    assign bus.m_a    = m_a_q;
    assign bus.m_b    = m_b_q;

endmodule
